instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage directly upstream of the instruction decoder/field parser. It holds the program counter and issues single-outstanding word requests to instruction memory over a req/ack handshake. Each fetched 32-bit word is presented, with its PC, to the decoder through a one-entry valid/ready output register. It accepts PC redirects (branch/JAL/JALR) from execute and discards any in-flight fetch on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
imem_req  output  1  memory request; held high until imem_ack.
imem_addr  output  32  word address of the request; stable while imem_req=1.
imem_ack  input  1  memory has returned imem_rdata this cycle; only meaningful while imem_req=1.
imem_rdata  input  32  instruction word, sampled when imem_req and imem_ack are both 1.
redirect  input  1  one-cycle pulse: restart fetch at redirect_pc.
redirect_pc  input  32  target PC; bits [1:0] ignored (forced to 0).
instr_valid  output  1  instr/instr_pc hold a valid instruction.
instr  output  32  instruction word to the decoder.
instr_pc  output  32  address instr was fetched from.
instr_ready  input  1  decoder accepts the instruction when instr_valid=1.

Behaviour:
- Registers: pc (next fetch address), imem_addr, output register (instr_valid, instr, instr_pc), state.
- Reset (rst_n=0, asynchronous): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0.
- States: IDLE, FETCH, FULL, FLUSH. imem_req=1 exactly in FETCH and FLUSH.
- IDLE: next cycle FETCH with imem_addr<=pc. The first request is visible on the first cycle after the first clk edge following rst_n release.
- FETCH, ack=1, no redirect:
  - instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1.
  - pc<=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - Next state FULL.
- FETCH, ack=0, no redirect: stay; imem_req and imem_addr are held.
- FULL: imem_req=0, outputs are stable.
  - When instr_valid & instr_ready: instr_valid<=0, imem_addr<=pc, next FETCH.
  - Throughput with zero-wait memory is 1 instruction per 2 cycles.
- Redirect, with tgt = {redirect_pc[31:2],2'b00}. Redirect has priority over every other event in the same cycle.
  - IDLE or FULL: instr_valid<=0 (a simultaneous instr_ready handshake is void), pc<=tgt, imem_addr<=tgt, next FETCH.
  - FETCH with ack the same cycle: discard imem_rdata (instr_valid stays 0), pc<=tgt, imem_addr<=tgt, next FETCH.
  - FETCH without ack: pc<=tgt, next FLUSH. imem_req and imem_addr are held at the old address; the memory handshake is never abandoned.
  - FLUSH with a further redirect: pc<=newest tgt. If ack arrives in the same cycle, also apply the FLUSH ack rule below.
- FLUSH, ack=1: discard data, imem_addr<=pc, next FETCH. No instruction from a killed fetch ever reaches the output.
- Invariant: instr_valid=1 only in FULL. The decoder sees no instruction while a request is outstanding.
- pc never changes except on an accepted fetch (+4) or a redirect.
- Reset asserted mid-transaction drops imem_req immediately (asynchronous). Memory must tolerate an abandoned request on reset only.

Test Plan:
- Reset release, RESET_PC=0, zero-wait ack → imem_addr sequence 0,4,8; instr_valid pulses with instr_pc 0,4,8 and instr equal to the memory words (e.g. 32'h00500093 at 0); one instruction every 2 cycles with instr_ready=1.
- Backpressure: hold instr_ready=0 for 5 cycles in FULL → instr/instr_pc stable, imem_req=0 throughout; release → next request at instr_pc+4.
- Wait states: ack delayed 3 cycles → imem_req and imem_addr are constant for 4 cycles; exactly one instruction is delivered.
- Redirect in FETCH without ack (ack 2 cycles later), redirect_pc=32'h0000_0103 → old word discarded, next imem_addr=32'h100, first delivered instr_pc=32'h100.
- Redirect in the same cycle as ack, and redirect in FULL with simultaneous instr_ready → no stale instruction delivered; next fetch at target; two back-to-back redirects in FLUSH use the second target.
- PC wrap: redirect to 32'hFFFF_FFFC → delivered instr_pc FFFF_FFFC, then 0. Async reset asserted mid-FETCH → imem_req=0 and instr_valid=0 without a clock edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC, issues one outstanding word request
// at a time to instruction memory, and hands each fetched word (with its PC)
// to the decoder through a single-entry valid/ready output register.
// Redirects restart fetch at a new target; an in-flight request that cannot
// be cancelled is drained in FLUSH and its data dropped.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction memory
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    // redirect from execute
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    // decoder side
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] pc_inc;
    logic        accept;

    // Redirect target is always word aligned; low bits are dropped.
    assign tgt    = redirect_pc & 32'hFFFF_FFFC;
    // Natural 32-bit overflow gives the FFFF_FFFC -> 0 wrap.
    assign pc_inc = pc + 32'd4;
    assign accept = instr_valid & instr_ready;

    // A request is outstanding exactly in FETCH and FLUSH. Derived from the
    // state register so an asynchronous reset drops it immediately.
    assign imem_req = (state == FETCH) || (state == FLUSH);

    // Fetch control FSM: PC, request address, output register and state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_addr   <= 32'h0;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (redirect) begin
                        instr_valid <= 1'b0;
                        pc          <= tgt;
                        imem_addr   <= tgt;
                    end else begin
                        imem_addr <= pc;
                    end
                end

                FETCH: begin
                    if (redirect) begin
                        pc <= tgt;
                        if (imem_ack) begin
                            // Returned word belongs to the killed path.
                            imem_addr <= tgt;
                            state     <= FETCH;
                        end else begin
                            // Request must complete at the old address first.
                            state <= FLUSH;
                        end
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        pc          <= pc_inc;
                        state       <= FULL;
                    end
                end

                FULL: begin
                    if (redirect) begin
                        // Any handshake this cycle is void; instruction dies.
                        instr_valid <= 1'b0;
                        pc          <= tgt;
                        imem_addr   <= tgt;
                        state       <= FETCH;
                    end else if (accept) begin
                        instr_valid <= 1'b0;
                        imem_addr   <= pc;
                        state       <= FETCH;
                    end
                end

                FLUSH: begin
                    // Newest redirect wins; data from the drained request is dropped.
                    if (redirect) begin
                        pc <= tgt;
                    end
                    if (imem_ack) begin
                        imem_addr <= redirect ? tgt : pc;
                        state     <= FETCH;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a per-cycle vector table drives the
// memory ack, redirect and decoder ready, and checks the registered outputs;
// hand-written sequences cover reset behaviour.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory contents: a known instruction at 0, an address-derived word elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
        end
    endtask

    typedef struct {
        logic        ack;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic ack, input logic redir, input logic [31:0] rpc,
                                input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_ipc);
        vec_t v;
        v.ack = ack; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_ipc = e_ipc;
        return v;
    endfunction

    initial begin
        // Each row: inputs applied for the coming edge, and outputs expected
        // before that edge.       ack redir rpc           rdy   req addr          vld ipc
        // zero-wait stream 0,4,8
        tv.push_back(mk(0, 0, 32'h0,         1,    0, 32'h0,         0, 32'h0));
        tv.push_back(mk(1, 0, 32'h0,         1,    1, 32'h0,         0, 32'h0));
        tv.push_back(mk(0, 0, 32'h0,         1,    0, 32'h0,         1, 32'h0));
        tv.push_back(mk(1, 0, 32'h0,         1,    1, 32'h4,         0, 32'h0));
        tv.push_back(mk(0, 0, 32'h0,         1,    0, 32'h4,         1, 32'h4));
        tv.push_back(mk(1, 0, 32'h0,         1,    1, 32'h8,         0, 32'h4));
        // backpressure for 5 cycles in FULL
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(0, 0, 32'h0,     0,    0, 32'h8,         1, 32'h8));
        tv.push_back(mk(0, 0, 32'h0,         1,    0, 32'h8,         1, 32'h8));
        // 3 wait states then ack at 12
        for (int i = 0; i < 3; i++)
            tv.push_back(mk(0, 0, 32'h0,     1,    1, 32'hC,         0, 32'h8));
        tv.push_back(mk(1, 0, 32'h0,         1,    1, 32'hC,         0, 32'h8));
        tv.push_back(mk(0, 0, 32'h0,         1,    0, 32'hC,         1, 32'hC));
        // redirect in FETCH without ack, drain old request at 0x10
        tv.push_back(mk(0, 1, 32'h103,       1,    1, 32'h10,        0, 32'hC));
        tv.push_back(mk(0, 0, 32'h0,         1,    1, 32'h10,        0, 32'hC));
        tv.push_back(mk(1, 0, 32'h0,         1,    1, 32'h10,        0, 32'hC));
        tv.push_back(mk(1, 0, 32'h0,         1,    1, 32'h100,       0, 32'hC));
        tv.push_back(mk(0, 0, 32'h0,         1,    0, 32'h100,       1, 32'h100));
        // redirect together with ack: word at 0x104 dropped
        tv.push_back(mk(1, 1, 32'h200,       1,    1, 32'h104,       0, 32'h100));
        tv.push_back(mk(1, 0, 32'h0,         1,    1, 32'h200,       0, 32'h100));
        // redirect in FULL with simultaneous ready
        tv.push_back(mk(0, 1, 32'h300,       1,    0, 32'h200,       1, 32'h200));
        tv.push_back(mk(0, 0, 32'h0,         1,    1, 32'h300,       0, 32'h200));
        // back-to-back redirects in FLUSH, last one coincides with ack
        tv.push_back(mk(0, 1, 32'h400,       1,    1, 32'h300,       0, 32'h200));
        tv.push_back(mk(0, 1, 32'h500,       1,    1, 32'h300,       0, 32'h200));
        tv.push_back(mk(1, 1, 32'h602,       1,    1, 32'h300,       0, 32'h200));
        tv.push_back(mk(1, 0, 32'h0,         1,    1, 32'h600,       0, 32'h200));
        tv.push_back(mk(0, 0, 32'h0,         0,    0, 32'h600,       1, 32'h600));
        // PC wrap
        tv.push_back(mk(0, 1, 32'hFFFF_FFFF, 0,    0, 32'h600,       1, 32'h600));
        tv.push_back(mk(1, 0, 32'h0,         1,    1, 32'hFFFF_FFFC, 0, 32'h600));
        tv.push_back(mk(0, 0, 32'h0,         1,    0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC));
        tv.push_back(mk(1, 0, 32'h0,         1,    1, 32'h0,         0, 32'hFFFF_FFFC));
        tv.push_back(mk(0, 0, 32'h0,         0,    0, 32'h0,         1, 32'h0));

        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req",   -1, {31'h0, imem_req},    32'h0);
        chk("reset_addr",  -1, imem_addr,            32'h0);
        chk("reset_valid", -1, {31'h0, instr_valid}, 32'h0);
        chk("reset_instr", -1, instr,                32'h0);
        chk("reset_ipc",   -1, instr_pc,             32'h0);
        rst_n = 1'b1;

        foreach (tv[r]) begin
            imem_ack    = tv[r].ack;
            redirect    = tv[r].redir;
            redirect_pc = tv[r].rpc;
            instr_ready = tv[r].rdy;
            #1;
            chk("imem_req",    r, {31'h0, imem_req},    {31'h0, tv[r].e_req});
            chk("imem_addr",   r, imem_addr,            tv[r].e_addr);
            chk("instr_valid", r, {31'h0, instr_valid}, {31'h0, tv[r].e_valid});
            chk("instr_pc",    r, instr_pc,             tv[r].e_ipc);
            if (tv[r].e_valid)
                chk("instr", r, instr, mem_word(tv[r].e_ipc));
            @(negedge clk);
        end

        // Release the held instruction, then assert reset mid-FETCH.
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        #1;
        chk("fetch_before_rst_req",  100, {31'h0, imem_req}, 32'h1);
        chk("fetch_before_rst_addr", 100, imem_addr,         32'h4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req",   101, {31'h0, imem_req},    32'h0);
        chk("async_rst_valid", 101, {31'h0, instr_valid}, 32'h0);
        chk("async_rst_addr",  101, imem_addr,            32'h0);
        chk("async_rst_ipc",   101, instr_pc,             32'h0);

        // Redirect applied in IDLE goes straight to the target.
        @(negedge clk);
        rst_n       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0ABD;
        @(negedge clk);
        redirect = 1'b0;
        imem_ack = 1'b1;
        #1;
        chk("idle_redir_req",  102, {31'h0, imem_req}, 32'h1);
        chk("idle_redir_addr", 102, imem_addr,         32'hABC);
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        chk("idle_redir_valid", 103, {31'h0, instr_valid}, 32'h1);
        chk("idle_redir_ipc",   103, instr_pc,             32'hABC);
        chk("idle_redir_instr", 103, instr,                mem_word(32'hABC));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
